// File: rtl/alu_flag_stage_if.sv
// Handshake bundle between the adder, the flag stage and the control unit.
// The slave modport is the flag stage. The master modport is the environment
// that drives adder results in and consumes flagged results.
interface alu_flag_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_sum;
  logic             in_cout;
  logic             in_a_sign;
  logic             in_b_sign;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [3:0]       out_flags;
  logic             clr_count;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, in_sum, in_cout, in_a_sign, in_b_sign, out_ready, clr_count,
    input  in_ready, out_valid, out_sum, out_flags, ovf_count
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_a_sign, in_b_sign, out_ready, clr_count,
    output in_ready, out_valid, out_sum, out_flags, ovf_count
  );
endinterface

// File: rtl/alu_flag_stage.sv
// Registered output stage behind the 32-bit adder. It derives the N/Z/C/V
// flags and buffers results in a main + skid register pair, so in_ready
// comes from a flop and never depends on out_ready. It also keeps a
// saturating count of accepted signed overflows.
module alu_flag_stage #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_flag_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Flag order is {N, Z, C, V}. V is valid for A+B+Cin because it only looks
  // at the operand signs and the result sign.
  function automatic logic [3:0] calc_flags(input logic [31:0] sum, input logic cout,
                                            input logic a_sign, input logic b_sign);
    logic n, z, v;
    n = sum[31];
    z = (sum == 32'd0);
    v = (a_sign == b_sign) & (sum[31] != a_sign);
    return {n, z, cout, v};
  endfunction

  state_t           state_r, next_state_s;
  logic             out_valid_r, in_ready_r;
  logic [31:0]      main_sum_r, skid_sum_r;
  logic [3:0]       main_flags_r, skid_flags_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       in_flags_s;
  logic             in_fire_s, out_fire_s;
  logic             load_main_s, main_from_skid_s, load_skid_s;

  assign in_flags_s = calc_flags(bus.in_sum, bus.in_cout, bus.in_a_sign, bus.in_b_sign);
  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;

  // Occupancy transitions and register load strobes for the two entries.
  always_comb begin
    next_state_s     = state_r;
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          next_state_s = ONE;
          load_main_s  = 1'b1;
        end else begin
          next_state_s = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s & out_fire_s) begin
          // Pass-through: replace the drained result with no bubble.
          load_main_s = 1'b1;
        end else if (out_fire_s) begin
          next_state_s = EMPTY;
        end else if (in_fire_s) begin
          // Consumer stalled: park the new result in the skid entry.
          next_state_s = TWO;
          load_skid_s  = 1'b1;
        end else begin
          next_state_s = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so the only event is a drain.
        if (out_fire_s) begin
          next_state_s     = ONE;
          load_main_s      = 1'b1;
          main_from_skid_s = 1'b1;
        end else begin
          next_state_s = TWO;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
  end

  // State and the registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s != EMPTY);
      in_ready_r  <= (next_state_s != TWO);
    end
  end

  // Payload of the main and skid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_sum_r   <= 32'd0;
      main_flags_r <= 4'b0000;
      skid_sum_r   <= 32'd0;
      skid_flags_r <= 4'b0000;
    end else begin
      if (load_main_s) begin
        if (main_from_skid_s) begin
          main_sum_r   <= skid_sum_r;
          main_flags_r <= skid_flags_r;
        end else begin
          main_sum_r   <= bus.in_sum;
          main_flags_r <= in_flags_s;
        end
      end
      if (load_skid_s) begin
        skid_sum_r   <= bus.in_sum;
        skid_flags_r <= in_flags_s;
      end
    end
  end

  // Saturating overflow counter, counted at accept time; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (bus.clr_count) begin
      cnt_r <= CNT_ZERO;
    end else if (in_fire_s & in_flags_s[0] & (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = main_sum_r;
  assign bus.out_flags = main_flags_r;
  assign bus.ovf_count = cnt_r;

endmodule
